// File: rtl/seg_scan_mux.sv
// Two-digit 7-segment scan multiplexer with per-frame digit snapshot and blanking guard.
// Optional build macro LEADING_ZERO_BLANK_EN darkens the tens slot when the latched tens digit is 0.
module seg_scan_mux #(
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  output logic [0:6] seg,
  output logic [1:0] an,
  output logic       frame_tick
);

  typedef enum logic [2:0] {IDLE, B_ONES, S_ONES, B_TENS, S_TENS} state_t;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   timer, timer_nxt;
  logic [3:0]         ones_q, tens_q, ones_nxt, tens_nxt;
  logic [0:6]         seg_nxt;
  logic [1:0]         an_nxt;
  logic               enter_frame;

  function automatic logic [0:6] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1111110;
      4'd1:    decode = 7'b0110000;
      4'd2:    decode = 7'b1101101;
      4'd3:    decode = 7'b1111001;
      4'd4:    decode = 7'b0110011;
      4'd5:    decode = 7'b1011011;
      4'd6:    decode = 7'b1011111;
      4'd7:    decode = 7'b1110000;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1111011;
      default: decode = 7'b0000001;
    endcase
  endfunction

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    timer_nxt = timer + 1'b1;
    if (!en) begin
      state_nxt = IDLE;
      timer_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = B_ONES;
          timer_nxt = '0;
        end
        B_ONES: if (timer == BLANK_LAST) begin
          state_nxt = S_ONES;
          timer_nxt = '0;
        end
        S_ONES: if (timer == SLOT_LAST) begin
          state_nxt = B_TENS;
          timer_nxt = '0;
        end
        B_TENS: if (timer == BLANK_LAST) begin
          state_nxt = S_TENS;
          timer_nxt = '0;
        end
        S_TENS: if (timer == SLOT_LAST) begin
          state_nxt = B_ONES;
          timer_nxt = '0;
        end
        default: begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end
      endcase
    end

    // Snapshot only on entry to B_ONES so a frame never mixes old and new digits.
    enter_frame = (state_nxt == B_ONES) && (state != B_ONES);
    ones_nxt    = enter_frame ? ones : ones_q;
    tens_nxt    = enter_frame ? tens : tens_q;

    // Outputs are computed for the next state so the registered outputs line up with it.
    seg_nxt = '0;
    an_nxt  = 2'b00;
    case (state_nxt)
      S_ONES: begin
        an_nxt  = 2'b01;
        seg_nxt = decode(ones_nxt);
      end
      S_TENS: begin
`ifdef LEADING_ZERO_BLANK_EN
        if (tens_nxt != 4'd0) begin
          an_nxt  = 2'b10;
          seg_nxt = decode(tens_nxt);
        end
`else
        an_nxt  = 2'b10;
        seg_nxt = decode(tens_nxt);
`endif
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      ones_q     <= '0;
      tens_q     <= '0;
      seg        <= '0;
      an         <= 2'b00;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      ones_q     <= ones_nxt;
      tens_q     <= tens_nxt;
      seg        <= seg_nxt;
      an         <= an_nxt;
      frame_tick <= enter_frame;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with REFRESH_DIV=4, BLANK_CYCLES=1 (10-cycle frame).
// Build with +define+LEADING_ZERO_BLANK_EN to check the leading-zero blanking variant.
module tb_seg_scan_mux;

  logic       clk;
  logic       reset;
  logic       en;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [0:6] seg;
  logic [1:0] an;
  logic       frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  seg_scan_mux #(.REFRESH_DIV(4), .BLANK_CYCLES(1), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .ones       (ones),
    .tens       (tens),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [0:6] SEG_0    = 7'b1111110;
  localparam logic [0:6] SEG_1    = 7'b0110000;
  localparam logic [0:6] SEG_2    = 7'b1101101;
  localparam logic [0:6] SEG_3    = 7'b1111001;
  localparam logic [0:6] SEG_4    = 7'b0110011;
  localparam logic [0:6] SEG_5    = 7'b1011011;
  localparam logic [0:6] SEG_6    = 7'b1011111;
  localparam logic [0:6] SEG_7    = 7'b1110000;
  localparam logic [0:6] SEG_8    = 7'b1111111;
  localparam logic [0:6] SEG_9    = 7'b1111011;
  localparam logic [0:6] SEG_DASH = 7'b0000001;

  // Frame position p: 0 = B_ONES, 1..4 = S_ONES, 5 = B_TENS, 6..9 = S_TENS.
  function automatic logic [1:0] exp_an(input int p, input bit tens_dark);
    if (p >= 1 && p <= 4) return 2'b01;
    if (p >= 6 && p <= 9) return tens_dark ? 2'b00 : 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [0:6] exp_seg(input int p, input logic [0:6] so,
                                          input logic [0:6] st, input bit tens_dark);
    if (p >= 1 && p <= 4) return so;
    if (p >= 6 && p <= 9) return tens_dark ? 7'b0000000 : st;
    return 7'b0000000;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    en    = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en    = 1'b0;
    ones  = 4'd0;
    tens  = 4'd0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (an !== 2'b00) begin n_fail++; $display("FAIL reset_an got=%b exp=00", an); end
    n_checks++;
    if (seg !== 7'b0000000) begin n_fail++; $display("FAIL reset_seg got=%b exp=0000000", seg); end
    n_checks++;
    if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got=%b exp=0", frame_tick); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (an !== 2'b00 || seg !== 7'b0000000 || frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset an=%b seg=%b tick=%b exp 00/0000000/0", an, seg, frame_tick);
    end
  endtask

  task automatic test_basic_scan();
    apply_reset();
    ones = 4'd7;
    tens = 4'd4;
    en   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (an !== exp_an(i % 10, 1'b0) || seg !== exp_seg(i % 10, SEG_7, SEG_4, 1'b0)
          || frame_tick !== (i % 10 == 0)) begin
        n_fail++;
        $display("FAIL basic_scan cyc=%0d an=%b seg=%b tick=%b exp an=%b seg=%b tick=%b",
                 i, an, seg, frame_tick, exp_an(i % 10, 1'b0),
                 exp_seg(i % 10, SEG_7, SEG_4, 1'b0), (i % 10 == 0));
      end
    end
  endtask

  task automatic test_snapshot();
    logic [0:6] so, st;
    apply_reset();
    ones = 4'd9;
    tens = 4'd1;
    en   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      so = (i < 10) ? SEG_9 : SEG_0;
      st = (i < 10) ? SEG_1 : SEG_2;
      n_checks++;
      if (an !== exp_an(i % 10, 1'b0) || seg !== exp_seg(i % 10, so, st, 1'b0)
          || frame_tick !== (i % 10 == 0)) begin
        n_fail++;
        $display("FAIL snapshot cyc=%0d an=%b seg=%b tick=%b exp an=%b seg=%b tick=%b",
                 i, an, seg, frame_tick, exp_an(i % 10, 1'b0),
                 exp_seg(i % 10, so, st, 1'b0), (i % 10 == 0));
      end
      if (i == 2) begin
        ones = 4'd0;
        tens = 4'd2;
      end
    end
  endtask

  task automatic test_invalid_bcd();
    apply_reset();
    ones = 4'd12;
    tens = 4'd4;
    en   = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_checks++;
      if (an === 2'b11 || (an === 2'b00 && seg !== 7'b0000000)) begin
        n_fail++;
        $display("FAIL invariant cyc=%0d an=%b seg=%b exp an!=11 and dark seg when an=00", i, an, seg);
      end
      n_checks++;
      if (an !== exp_an(i % 10, 1'b0) || seg !== exp_seg(i % 10, SEG_DASH, SEG_4, 1'b0)) begin
        n_fail++;
        $display("FAIL invalid_bcd cyc=%0d an=%b seg=%b exp an=%b seg=%b", i, an, seg,
                 exp_an(i % 10, 1'b0), exp_seg(i % 10, SEG_DASH, SEG_4, 1'b0));
      end
    end
  endtask

  task automatic test_en_drop();
    apply_reset();
    ones = 4'd3;
    tens = 4'd8;
    en   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (an !== exp_an(i, 1'b0) || seg !== exp_seg(i, SEG_3, SEG_8, 1'b0)) begin
        n_fail++;
        $display("FAIL en_pre cyc=%0d an=%b seg=%b exp an=%b seg=%b", i, an, seg,
                 exp_an(i, 1'b0), exp_seg(i, SEG_3, SEG_8, 1'b0));
      end
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (an !== 2'b00 || seg !== 7'b0000000 || frame_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL en_drop cyc=%0d an=%b seg=%b tick=%b exp 00/0000000/0", i, an, seg, frame_tick);
      end
    end
    ones = 4'd5;
    tens = 4'd6;
    en   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (an !== exp_an(i, 1'b0) || seg !== exp_seg(i, SEG_5, SEG_6, 1'b0)
          || frame_tick !== (i == 0)) begin
        n_fail++;
        $display("FAIL en_restart cyc=%0d an=%b seg=%b tick=%b exp an=%b seg=%b tick=%b",
                 i, an, seg, frame_tick, exp_an(i, 1'b0), exp_seg(i, SEG_5, SEG_6, 1'b0), (i == 0));
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    ones = 4'd7;
    tens = 4'd4;
    en   = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    n_checks++;
    if (an !== 2'b01 || seg !== SEG_7) begin
      n_fail++;
      $display("FAIL async_pre an=%b seg=%b exp 01/%b", an, seg, SEG_7);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (an !== 2'b00 || seg !== 7'b0000000 || frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset an=%b seg=%b tick=%b exp 00/0000000/0", an, seg, frame_tick);
    end
    en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (an !== 2'b00 || seg !== 7'b0000000 || frame_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL async_wait cyc=%0d an=%b seg=%b tick=%b exp dark idle", i, an, seg, frame_tick);
      end
    end
    ones = 4'd2;
    tens = 4'd9;
    en   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (an !== exp_an(i, 1'b0) || seg !== exp_seg(i, SEG_2, SEG_9, 1'b0)
          || frame_tick !== (i == 0)) begin
        n_fail++;
        $display("FAIL async_restart cyc=%0d an=%b seg=%b tick=%b exp an=%b seg=%b tick=%b",
                 i, an, seg, frame_tick, exp_an(i, 1'b0), exp_seg(i, SEG_2, SEG_9, 1'b0), (i == 0));
      end
    end
  endtask

  task automatic test_leading_zero();
    bit dark;
`ifdef LEADING_ZERO_BLANK_EN
    dark = 1'b1;
`else
    dark = 1'b0;
`endif
    apply_reset();
    ones = 4'd5;
    tens = 4'd0;
    en   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (an !== exp_an(i % 10, dark) || seg !== exp_seg(i % 10, SEG_5, SEG_0, dark)
          || frame_tick !== (i % 10 == 0)) begin
        n_fail++;
        $display("FAIL leading_zero cyc=%0d an=%b seg=%b tick=%b exp an=%b seg=%b tick=%b",
                 i, an, seg, frame_tick, exp_an(i % 10, dark),
                 exp_seg(i % 10, SEG_5, SEG_0, dark), (i % 10 == 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_snapshot();
    test_invalid_bcd();
    test_en_drop();
    test_async_reset();
    test_leading_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
